pot_scan_ctrl: RTL and testbench

Scheduler that owns the shared A2D SPI master and round-robins conversions of the six slide potentiometers: LP, B1, B2, B3, HP and VOLUME. It sits between the SPI master that drives the ADC128S (A2D_SS_n/SCLK/MOSI/MISO) and the equalizer band-gain and volume logic. It exploits the ADC128S pipeline, where each transaction returns the channel addressed by the previous one, so one scan takes 7 transactions. It raises scan_valid after the first full scan; top level gates AMP_ON with it.

---
 rtl/pot_scan_ctrl_pkg.sv | 25 ++
 rtl/pot_scan_ctrl_if.sv | 11 +
 rtl/pot_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_pot_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pot_scan_ctrl_pkg.sv
// Shared types and constants for the potentiometer scan controller.
// Covers the FSM state type, the slot-to-ADC-channel map and the SPI command builder.
package pot_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } scan_state_t;

    localparam int NUM_POTS     = 6;
    localparam int NUM_SLOTS    = 7;
    localparam int CMD_CHAN_LSB = 11;

    // Slot 6 re-sends channel 1 only to flush the VOLUME result out of the ADC pipeline.
    localparam logic [2:0] POT_CHAN [0:6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd1};

    function automatic logic [15:0] make_cmd(input logic [2:0] chan);
        logic [15:0] cmd;
        cmd = 16'h0000;
        cmd[CMD_CHAN_LSB +: 3] = chan;
        return cmd;
    endfunction

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// Bundle of signals between the scan controller and the external A2D SPI master.
// Handshake: spi_wrt is a one-cycle start strobe with spi_cmd valid alongside; spi_done is a one-cycle completion pulse with spi_rd valid alongside.
interface pot_scan_ctrl_if;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;

    modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd);
    modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd);
endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin scheduler of the shared ADC128S SPI master over the six slide pots.
// One scan is seven transactions because each returns the channel addressed by the previous one.
module pot_scan_ctrl
    import pot_scan_ctrl_pkg::*;
#(
    parameter logic [15:0] SCAN_INTERVAL = 16'd1024,
    parameter logic [15:0] TIMEOUT_CYC   = 16'd4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    pot_scan_ctrl_if.master        spi,
    output logic [11:0]            lp_pot,
    output logic [11:0]            b1_pot,
    output logic [11:0]            b2_pot,
    output logic [11:0]            b3_pot,
    output logic [11:0]            hp_pot,
    output logic [11:0]            vol_pot,
    output logic                   scan_done,
    output logic                   scan_valid,
    output logic                   err,
    output scan_state_t            state_dbg
);

    scan_state_t state_q, state_d;
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] pot_q [0:NUM_POTS-1];
    logic [11:0] pot_d [0:NUM_POTS-1];
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        scan_done_q, scan_done_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_comb begin
        state_d     = state_q;
        icnt_d      = icnt_q;
        tcnt_d      = tcnt_q;
        idx_d       = idx_q;
        for (int i = 0; i < NUM_POTS; i++) pot_d[i] = pot_q[i];
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        scan_done_d = 1'b0;
        valid_d     = valid_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                // Counter parks at the terminal value while disabled so a later en starts at once.
                if (icnt_q == SCAN_INTERVAL - 16'd1) begin
                    if (en) begin
                        icnt_d  = 16'd0;
                        idx_d   = 3'd0;
                        state_d = ISSUE;
                    end
                end else begin
                    icnt_d = icnt_q + 16'd1;
                end
            end
            ISSUE: begin
                wrt_d   = 1'b1;
                cmd_d   = make_cmd(POT_CHAN[idx_q]);
                tcnt_d  = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done wins over a simultaneous timeout expiry.
                if (spi.spi_done) begin
                    for (int i = 0; i < NUM_POTS; i++) begin
                        if (idx_q == 3'(i + 1)) pot_d[i] = spi.spi_rd[11:0];
                    end
                    if (idx_q == 3'(NUM_SLOTS - 1)) begin
                        state_d     = IDLE;
                        scan_done_d = 1'b1;
                        valid_d     = 1'b1;
                        err_d       = 1'b0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                    end
                end else if (tcnt_q == TIMEOUT_CYC - 16'd1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            icnt_q      <= 16'd0;
            tcnt_q      <= 16'd0;
            idx_q       <= 3'd0;
            for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= 12'h000;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            scan_done_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            icnt_q      <= icnt_d;
            tcnt_q      <= tcnt_d;
            idx_q       <= idx_d;
            for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= pot_d[i];
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            scan_done_q <= scan_done_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign spi.spi_wrt = wrt_q;
    assign spi.spi_cmd = cmd_q;
    assign lp_pot      = pot_q[0];
    assign b1_pot      = pot_q[1];
    assign b2_pot      = pot_q[2];
    assign b3_pot      = pot_q[3];
    assign hp_pot      = pot_q[4];
    assign vol_pot     = pot_q[5];
    assign scan_done   = scan_done_q;
    assign scan_valid  = valid_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl with a pipelined ADC responder driven from the main sequence.
// Short scan interval and timeout keep the run small.
module tb_pot_scan_ctrl;
    import pot_scan_ctrl_pkg::*;

    localparam int SI = 32;
    localparam int TO = 128;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] lp_pot, b1_pot, b2_pot, b3_pot, hp_pot, vol_pot;
    logic        scan_done, scan_valid, err;
    scan_state_t state_dbg;

    pot_scan_ctrl_if sif ();

    pot_scan_ctrl #(.SCAN_INTERVAL(16'(SI)), .TIMEOUT_CYC(16'(TO))) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spi(sif),
        .lp_pot(lp_pot), .b1_pot(b1_pot), .b2_pot(b2_pot), .b3_pot(b3_pot),
        .hp_pot(hp_pot), .vol_pot(vol_pot),
        .scan_done(scan_done), .scan_valid(scan_valid), .err(err),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0]  prev_chan;
    int          last_cyc;
    logic [15:0] exp_cmd [0:6] = '{16'h0800, 16'h0000, 16'h2000, 16'h1000, 16'h1800, 16'h3800, 16'h0800};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_wrt(input int max_cyc, output int cyc, output bit found);
        cyc = 0;
        found = 1'b0;
        while (cyc < max_cyc && !found) begin
            @(negedge clk);
            cyc++;
            if (sif.spi_wrt) found = 1'b1;
        end
    endtask

    // Called while spi_wrt is visible; answers with the previously addressed channel.
    task automatic respond(input int slot, input logic [11:0] base, input bit do_resp);
        logic [2:0] cur_chan;
        cur_chan = sif.spi_cmd[13:11];
        chk($sformatf("cmd_slot%0d", slot), sif.spi_cmd, exp_cmd[slot]);
        if (do_resp) begin
            repeat (3) @(negedge clk);
            sif.spi_done = 1'b1;
            sif.spi_rd   = {4'hA, base + {9'd0, prev_chan}};
            @(negedge clk);
            sif.spi_done = 1'b0;
            sif.spi_rd   = 16'h0000;
        end
        prev_chan = cur_chan;
    endtask

    task automatic serve(input int slot, input logic [11:0] base, input bit do_resp, input int exp_gap);
        int cyc;
        bit found;
        wait_wrt(SI + TO + 8, cyc, found);
        last_cyc = cyc;
        chk($sformatf("wrt_seen_slot%0d", slot), 16'(found), 16'd1);
        if (exp_gap > 0) chk($sformatf("wrt_gap_slot%0d", slot), 16'(cyc), 16'(exp_gap));
        respond(slot, base, do_resp);
    endtask

    task automatic chk_pots(input string tag, input logic [11:0] l, input logic [11:0] p1,
                            input logic [11:0] p2, input logic [11:0] p3,
                            input logic [11:0] h, input logic [11:0] v);
        chk({tag, "_lp"},  16'(lp_pot),  16'(l));
        chk({tag, "_b1"},  16'(b1_pot),  16'(p1));
        chk({tag, "_b2"},  16'(b2_pot),  16'(p2));
        chk({tag, "_b3"},  16'(b3_pot),  16'(p3));
        chk({tag, "_hp"},  16'(hp_pot),  16'(h));
        chk({tag, "_vol"}, 16'(vol_pot), 16'(v));
    endtask

    task automatic chk_reset(input string tag);
        chk_pots(tag, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
        chk({tag, "_wrt"},   16'(sif.spi_wrt), 16'd0);
        chk({tag, "_cmd"},   sif.spi_cmd,      16'h0000);
        chk({tag, "_done"},  16'(scan_done),   16'd0);
        chk({tag, "_valid"}, 16'(scan_valid),  16'd0);
        chk({tag, "_err"},   16'(err),         16'd0);
        chk({tag, "_state"}, 16'(state_dbg),   16'(IDLE));
    endtask

    // Called right after the slot-6 response; scan_done must be high now and low one cycle later.
    task automatic chk_scan_end(input string tag);
        chk({tag, "_done_hi"}, 16'(scan_done),  16'd1);
        chk({tag, "_valid"},   16'(scan_valid), 16'd1);
        chk({tag, "_err"},     16'(err),        16'd0);
        @(negedge clk);
        chk({tag, "_done_lo"}, 16'(scan_done),  16'd0);
    endtask

    initial begin
        int  cyc;
        bit  found;

        rst_n        = 1'b0;
        en           = 1'b1;
        sif.spi_done = 1'b0;
        sif.spi_rd   = 16'h0000;
        prev_chan    = 3'd0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");

        // Scan 1: first strobe SI+1 cycles after release, then a 2-cycle done-to-strobe gap.
        rst_n = 1'b1;
        for (int s = 0; s < 7; s++) serve(s, 12'h100, 1'b1, (s == 0) ? SI + 1 : 1);
        chk_scan_end("scan1");
        chk_pots("scan1", 12'h101, 12'h100, 12'h104, 12'h102, 12'h103, 12'h107);

        // Scan 2: ADC stalls on slot 4.
        for (int s = 0; s < 4; s++) serve(s, 12'h200, 1'b1, 0);
        serve(4, 12'h200, 1'b0, 0);
        repeat (TO - 1) @(negedge clk);
        chk("tmo_err_early", 16'(err), 16'd0);
        @(negedge clk);
        chk("tmo_err_set", 16'(err), 16'd1);
        chk("tmo_state", 16'(state_dbg), 16'(IDLE));
        chk("tmo_no_done", 16'(scan_done), 16'd0);
        chk_pots("tmo", 12'h201, 12'h200, 12'h204, 12'h102, 12'h103, 12'h107);
        @(negedge clk);
        chk("tmo_no_done2", 16'(scan_done), 16'd0);

        // Scan 3 recovers and clears err.
        for (int s = 0; s < 6; s++) serve(s, 12'h300, 1'b1, 0);
        chk("rec_err_held", 16'(err), 16'd1);
        serve(6, 12'h300, 1'b1, 0);
        chk_scan_end("scan3");
        chk_pots("scan3", 12'h301, 12'h300, 12'h304, 12'h302, 12'h303, 12'h307);

        // en low from reset: no traffic, then quick start once raised.
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_wrt(10000, cyc, found);
        chk("en0_no_wrt", 16'(found), 16'd0);
        en = 1'b1;
        wait_wrt(4, cyc, found);
        chk("en1_wrt_seen", 16'(found), 16'd1);
        chk("en1_latency_le2", 16'(cyc <= 2), 16'd1);
        respond(0, 12'h400, 1'b1);
        for (int s = 1; s < 7; s++) serve(s, 12'h400, 1'b1, 1);
        chk_scan_end("scan4");
        chk_pots("scan4", 12'h401, 12'h400, 12'h404, 12'h402, 12'h403, 12'h407);

        // en dropped during slot 2: scan still completes, nothing follows.
        serve(0, 12'h500, 1'b1, 0);
        serve(1, 12'h500, 1'b1, 0);
        wait_wrt(SI + 8, cyc, found);
        chk("endrop_wrt2", 16'(found), 16'd1);
        en = 1'b0;
        respond(2, 12'h500, 1'b1);
        for (int s = 3; s < 7; s++) serve(s, 12'h500, 1'b1, 1);
        chk_scan_end("scan5");
        chk_pots("scan5", 12'h501, 12'h500, 12'h504, 12'h502, 12'h503, 12'h507);
        wait_wrt(3 * SI, cyc, found);
        chk("endrop_no_more", 16'(found), 16'd0);

        // Reset during WAIT of slot 3, stray done afterwards, then a fresh scan.
        en = 1'b1;
        for (int s = 0; s < 3; s++) serve(s, 12'h600, 1'b1, 0);
        serve(3, 12'h600, 1'b0, 0);
        @(negedge clk);
        chk("rst_mid_state", 16'(state_dbg), 16'(WAIT));
        rst_n = 1'b0;
        #1;
        chk_reset("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < SI + 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                sif.spi_done = 1'b1;
                sif.spi_rd   = 16'h0ABC;
            end else if (cyc == 2) begin
                sif.spi_done = 1'b0;
                sif.spi_rd   = 16'h0000;
                chk_pots("stray", 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
            end
            if (sif.spi_wrt) found = 1'b1;
        end
        chk("fresh_wrt_seen", 16'(found), 16'd1);
        chk("fresh_wrt_latency", 16'(cyc), 16'(SI + 1));
        chk("fresh_cmd", sif.spi_cmd, 16'h0800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
